unidade_controle: RTL and testbench

Multicycle control unit for the RISC-V datapath: sequences the register bank, ULA, data memory, instruction register and program counter through fetch/decode/execute/memory/writeback steps. Decodes the registered instruction plus the ULA comparison flags and drives every write-enable and mux select the datapath needs, replacing per-instruction control written by hand. Also counts retired instructions and halts on `ecall` or an unsupported opcode.

---
 rtl/unidade_controle_if.sv | 44 ++++
 rtl/unidade_controle.sv | 198 +++++++++++++++++++
 tb/tb_unidade_controle.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_if.sv
// Control-unit <-> datapath bundle.
// master: control unit side. It receives the instruction register and the ULA flags, and it
//         drives every enable, mux select and status output.
// slave:  datapath (or bench) side. The directions are mirrored.
// Signals:
//   instr, flag_igual, flag_menor, flag_maior_u             datapath -> control
//   ir_we, pc_we, escolhe_constantePC, pc_src, WeR, WeM,
//   sel_dinR, soma_ou_subtrai, subtraindo, imediato,
//   sel_a_pc, sel_imm, halted, erro, instret                control -> datapath
interface unidade_controle_if #(
  parameter int unsigned CONT_W = 32
);
  logic [31:0]       instr;
  logic              flag_igual;
  logic              flag_menor;
  logic              flag_maior_u;
  logic              ir_we;
  logic              pc_we;
  logic              escolhe_constantePC;
  logic              pc_src;
  logic              WeR;
  logic              WeM;
  logic [1:0]        sel_dinR;
  logic              soma_ou_subtrai;
  logic              subtraindo;
  logic              imediato;
  logic              sel_a_pc;
  logic [2:0]        sel_imm;
  logic              halted;
  logic              erro;
  logic [CONT_W-1:0] instret;

  modport master (
    input  instr, flag_igual, flag_menor, flag_maior_u,
    output ir_we, pc_we, escolhe_constantePC, pc_src, WeR, WeM, sel_dinR,
           soma_ou_subtrai, subtraindo, imediato, sel_a_pc, sel_imm, halted, erro, instret
  );

  modport slave (
    output instr, flag_igual, flag_menor, flag_maior_u,
    input  ir_we, pc_we, escolhe_constantePC, pc_src, WeR, WeM, sel_dinR,
           soma_ou_subtrai, subtraindo, imediato, sel_a_pc, sel_imm, halted, erro, instret
  );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle RISC-V control unit. It steps the datapath through fetch, decode, execute,
// memory and writeback, counts retired instructions, and halts on ecall or on an
// unsupported encoding.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; every output is held at 0 while it is low
//   bus    unidade_controle_if.master (instruction/flags in, controls/status out)
module unidade_controle #(
  parameter logic [31:0] HALT_INSTR = 32'h00000073,
  parameter int unsigned CONT_W     = 32
) (
  input logic               clk,
  input logic               rst_n,
  unidade_controle_if.master bus
);

  typedef enum logic [2:0] {
    StBusca, StDecod, StExec, StMem, StWb, StDesvio, StSalto, StHalt
  } state_e;

  // Immediate format selects
  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmJ = 3'd3;
  localparam logic [2:0] ImmU = 3'd4;

  state_e            state_q, state_d;
  logic [CONT_W-1:0] instret_q, instret_d;
  logic              erro_q, erro_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_zero;
  logic       is_lw, is_sw, is_addi, is_add_sub, is_auipc, is_branch, is_jal, is_jalr;
  logic       add_sub_ok, branch_ok, taken;

  assign opcode  = bus.instr[6:0];
  assign funct3  = bus.instr[14:12];
  assign funct7  = bus.instr[31:25];
  assign rd_zero = (bus.instr[11:7] == 5'd0);

  assign is_lw      = (opcode == 7'b0000011);
  assign is_sw      = (opcode == 7'b0100011);
  assign is_addi    = (opcode == 7'b0010011);
  assign is_add_sub = (opcode == 7'b0110011);
  assign is_auipc   = (opcode == 7'b0010111);
  assign is_branch  = (opcode == 7'b1100011);
  assign is_jal     = (opcode == 7'b1101111);
  assign is_jalr    = (opcode == 7'b1100111);

  assign add_sub_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
  assign branch_ok  = (funct3 != 3'b010) && (funct3 != 3'b011);

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = bus.flag_igual;
      3'b001:  taken = !bus.flag_igual;
      3'b100:  taken = bus.flag_menor;
      3'b101:  taken = !bus.flag_menor;
      3'b110:  taken = !bus.flag_igual && !bus.flag_maior_u; // unsigned a < b
      3'b111:  taken = bus.flag_igual || bus.flag_maior_u;   // unsigned a >= b
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StBusca;
      instret_q <= '0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    instret_d               = instret_q;
    erro_d                  = erro_q;
    bus.ir_we               = 1'b0;
    bus.pc_we               = 1'b0;
    bus.escolhe_constantePC = 1'b0;
    bus.pc_src              = 1'b0;
    bus.WeR                 = 1'b0;
    bus.WeM                 = 1'b0;
    bus.sel_dinR            = 2'd0;
    bus.soma_ou_subtrai     = 1'b0;
    bus.subtraindo          = 1'b0;
    bus.imediato            = 1'b0;
    bus.sel_a_pc            = 1'b0;
    bus.sel_imm             = ImmI;
    bus.halted              = 1'b0;

    // The ULA setup for the EXEC-class instructions stays stable through MEM and WB
    if (state_q inside {StExec, StMem, StWb}) begin
      bus.soma_ou_subtrai = 1'b1;
      bus.subtraindo      = is_add_sub & bus.instr[30];
      bus.imediato        = !is_add_sub;
      bus.sel_a_pc        = is_auipc;
      if (is_sw)         bus.sel_imm = ImmS;
      else if (is_auipc) bus.sel_imm = ImmU;
      else               bus.sel_imm = ImmI;
    end

    unique case (state_q)
      StBusca: begin
        bus.ir_we = 1'b1;
        state_d   = StDecod;
      end
      StDecod: begin
        if (bus.instr == HALT_INSTR) begin
          state_d = StHalt;
        end else if (is_lw || is_sw || is_addi || is_auipc || (is_add_sub && add_sub_ok)) begin
          state_d = StExec;
        end else if (is_branch && branch_ok) begin
          state_d = StDesvio;
        end else if (is_jal || is_jalr) begin
          state_d = StSalto;
        end else begin
          state_d = StHalt;
          erro_d  = 1'b1;
        end
      end
      StExec: begin
        state_d = (is_lw || is_sw) ? StMem : StWb;
      end
      StMem: begin
        if (is_sw) begin
          bus.WeM   = 1'b1;
          bus.pc_we = 1'b1;
          instret_d = instret_q + 1'b1;
          state_d   = StBusca;
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        bus.WeR      = !rd_zero;
        bus.sel_dinR = is_lw ? 2'd1 : 2'd0;
        bus.pc_we    = 1'b1;
        instret_d    = instret_q + 1'b1;
        state_d      = StBusca;
      end
      StDesvio: begin
        bus.soma_ou_subtrai     = 1'b1;
        bus.subtraindo          = 1'b1;
        bus.imediato            = 1'b0;
        bus.sel_imm             = ImmB;
        bus.pc_we               = 1'b1;
        bus.escolhe_constantePC = taken;
        instret_d               = instret_q + 1'b1;
        state_d                 = StBusca;
      end
      StSalto: begin
        bus.WeR                 = !rd_zero;
        bus.sel_dinR            = 2'd2;
        bus.pc_we               = 1'b1;
        bus.escolhe_constantePC = 1'b1;
        bus.soma_ou_subtrai     = is_jalr;
        bus.imediato            = is_jalr;
        bus.sel_imm             = is_jalr ? ImmI : ImmJ;
        bus.pc_src              = is_jalr;
        instret_d               = instret_q + 1'b1;
        state_d                 = StBusca;
      end
      StHalt: begin
        bus.halted = 1'b1;
      end
      default: state_d = StBusca;
    endcase

    // Reset gates the outputs combinationally, so an in-flight write dies the instant rst_n falls
    if (!rst_n) begin
      bus.ir_we               = 1'b0;
      bus.pc_we               = 1'b0;
      bus.escolhe_constantePC = 1'b0;
      bus.pc_src              = 1'b0;
      bus.WeR                 = 1'b0;
      bus.WeM                 = 1'b0;
      bus.sel_dinR            = 2'd0;
      bus.soma_ou_subtrai     = 1'b0;
      bus.subtraindo          = 1'b0;
      bus.imediato            = 1'b0;
      bus.sel_a_pc            = 1'b0;
      bus.sel_imm             = ImmI;
      bus.halted              = 1'b0;
    end
  end

  assign bus.erro    = erro_q & rst_n;
  assign bus.instret = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  unidade_controle_if #(.CONT_W(32)) bus ();

  unidade_controle #(
    .HALT_INSTR(32'h00000073),
    .CONT_W    (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Values observed over one instruction
  int          obs_cycles, obs_wer, obs_wem, obs_ir_mid;
  logic [1:0]  obs_din;
  logic        obs_esc, obs_pcsrc, obs_sub, obs_imed, obs_apc, obs_halted, obs_erro;
  logic        obs_ir_start, obs_ir_next;
  logic [2:0]  obs_imm;
  logic [31:0] obs_ib, obs_ia;

  // Instruction classes used by the reference model
  localparam int CLw = 0, CSw = 1, CAddi = 2, CAdd = 3, CAuipc = 4, CBr = 5, CJal = 6, CJalr = 7;

  function automatic int cls(input logic [31:0] w);
    case (w[6:0])
      7'b0000011: return CLw;
      7'b0100011: return CSw;
      7'b0010011: return CAddi;
      7'b0110011: return CAdd;
      7'b0010111: return CAuipc;
      7'b1100011: return CBr;
      7'b1101111: return CJal;
      default:    return CJalr;
    endcase
  endfunction

  function automatic int exp_cycles(input int c);
    if (c == CLw) return 5;
    if (c == CBr || c == CJal || c == CJalr) return 3;
    return 4;
  endfunction

  // Branch outcome from the real operand relation, not from the flag encoding
  function automatic logic exp_taken(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input int c);
    case (c)
      CSw:    return 3'd1;
      CBr:    return 3'd2;
      CJal:   return 3'd3;
      CAuipc: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Runs one instruction starting in the fetch cycle; the ULA flags come from operands a/b.
  task automatic exec_instr(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    obs_wer = 0; obs_wem = 0; obs_ir_mid = 0; obs_din = 0; obs_esc = 0; obs_pcsrc = 0;
    obs_sub = 0; obs_imed = 0; obs_apc = 0; obs_imm = 0; obs_halted = 0; obs_erro = 0;
    obs_ir_next = 0; obs_cycles = 99;
    obs_ir_start = bus.ir_we;
    obs_ib = bus.instret;
    obs_ia = bus.instret;
    @(posedge clk); #1;
    bus.instr = w;
    bus.flag_igual = (a == b);
    bus.flag_menor = ($signed(a) < $signed(b));
    bus.flag_maior_u = (a > b);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (bus.ir_we) obs_ir_mid++;
      if (bus.WeR) begin obs_wer++; obs_din = bus.sel_dinR; end
      if (bus.WeM) obs_wem++;
      if (bus.halted) begin obs_cycles = c; obs_halted = 1; obs_erro = bus.erro; break; end
      if (bus.pc_we) begin
        obs_cycles = c; obs_esc = bus.escolhe_constantePC; obs_pcsrc = bus.pc_src;
        obs_sub = bus.subtraindo; obs_imed = bus.imediato; obs_apc = bus.sel_a_pc;
        obs_imm = bus.sel_imm;
        break;
      end
    end
    if (!obs_halted) begin
      @(negedge clk);
      obs_ia = bus.instret;
      obs_ir_next = bus.ir_we;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    bus.instr = 32'h00108863; bus.flag_igual = 1; bus.flag_menor = 0; bus.flag_maior_u = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.ir_we, bus.pc_we, bus.WeR, bus.WeM, bus.halted, bus.erro} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 000000",
        {bus.ir_we, bus.pc_we, bus.WeR, bus.WeM, bus.halted, bus.erro}); end
    checks++; if (bus.instret !== 32'd0) begin
      failures++; $display("FAIL reset_instret: got %0d want 0", bus.instret); end
    rst_n = 1'b1; #1;
    checks++; if (bus.ir_we !== 1'b1) begin
      failures++; $display("FAIL reset_first_fetch: got %b want 1", bus.ir_we); end
  endtask

  task automatic test_add_sub_lw();
    exec_instr(32'h002081B3, 32'd5, 32'd7); // add x3,x1,x2
    checks++; if (obs_cycles !== 4) begin failures++; $display("FAIL add_cycles: got %0d want 4", obs_cycles); end
    checks++; if (obs_wer !== 1 || obs_din !== 2'd0) begin
      failures++; $display("FAIL add_wer: got %0d/%0d want 1/0", obs_wer, obs_din); end
    checks++; if (obs_ia !== 32'd1) begin failures++; $display("FAIL add_instret: got %0d want 1", obs_ia); end
    exec_instr(32'h40208233, 32'd5, 32'd7); // sub x4,x1,x2
    checks++; if (obs_sub !== 1'b1) begin failures++; $display("FAIL sub_subtraindo: got %b want 1", obs_sub); end
    exec_instr(32'h00802203, 32'd0, 32'd0); // lw x4,8(x0)
    checks++; if (obs_cycles !== 5) begin failures++; $display("FAIL lw_cycles: got %0d want 5", obs_cycles); end
    checks++; if (obs_wer !== 1 || obs_din !== 2'd1) begin
      failures++; $display("FAIL lw_wer: got %0d/%0d want 1/1", obs_wer, obs_din); end
  endtask

  task automatic test_branch();
    exec_instr(32'h00108863, 32'd9, 32'd9); // beq x1,x1,+16
    checks++; if (obs_cycles !== 3 || obs_esc !== 1'b1) begin
      failures++; $display("FAIL beq_taken: got cyc=%0d esc=%b want cyc=3 esc=1", obs_cycles, obs_esc); end
    exec_instr(32'h00109863, 32'd9, 32'd9); // bne x1,x1,+16
    checks++; if (obs_cycles !== 3 || obs_esc !== 1'b0) begin
      failures++; $display("FAIL bne_not_taken: got cyc=%0d esc=%b want cyc=3 esc=0", obs_cycles, obs_esc); end
  endtask

  task automatic test_jump();
    exec_instr(32'h0080006F, 32'd0, 32'd0); // jal x0,+8
    checks++; if (obs_wer !== 0 || obs_esc !== 1'b1 || obs_imm !== 3'd3 || obs_pcsrc !== 1'b0) begin
      failures++; $display("FAIL jal_ctrl: got wer=%0d esc=%b imm=%0d src=%b want 0 1 3 0",
        obs_wer, obs_esc, obs_imm, obs_pcsrc); end
    exec_instr(32'h000280E7, 32'd0, 32'd0); // jalr x1,0(x5)
    checks++; if (obs_wer !== 1 || obs_din !== 2'd2 || obs_pcsrc !== 1'b1 || obs_imed !== 1'b1
                  || obs_imm !== 3'd0) begin
      failures++; $display("FAIL jalr_ctrl: got wer=%0d din=%0d src=%b imed=%b imm=%0d want 1 2 1 1 0",
        obs_wer, obs_din, obs_pcsrc, obs_imed, obs_imm); end
  endtask

  task automatic test_random();
    logic [2:0]  bf3 [6];
    logic [31:0] w, a, b;
    int          c;
    logic        want_wer, want_esc;
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      case ($urandom_range(0, 7))
        0: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
        1: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
        2: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
        3: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
        4: w[6:0] = 7'b0010111;
        5: begin w[6:0] = 7'b1100011; w[14:12] = bf3[$urandom_range(0, 5)]; end
        6: w[6:0] = 7'b1101111;
        default: begin w[6:0] = 7'b1100111; w[14:12] = 3'b000; end
      endcase
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      c = cls(w);
      exec_instr(w, a, b);
      want_wer = (c != CSw && c != CBr) && (w[11:7] != 5'd0);
      want_esc = (c == CJal || c == CJalr) || (c == CBr && exp_taken(w[14:12], a, b));
      checks++; if (obs_cycles !== exp_cycles(c)) begin
        failures++; $display("FAIL rnd_cycles w=%h: got %0d want %0d", w, obs_cycles, exp_cycles(c)); end
      checks++; if (obs_wer !== int'(want_wer)) begin
        failures++; $display("FAIL rnd_wer w=%h: got %0d want %0d", w, obs_wer, want_wer); end
      if (want_wer) begin
        checks++; if (obs_din !== ((c == CLw) ? 2'd1 : (c == CJal || c == CJalr) ? 2'd2 : 2'd0)) begin
          failures++; $display("FAIL rnd_din w=%h: got %0d", w, obs_din); end
      end
      checks++; if (obs_wem !== int'(c == CSw)) begin
        failures++; $display("FAIL rnd_wem w=%h: got %0d want %0d", w, obs_wem, c == CSw); end
      checks++; if (obs_esc !== want_esc) begin
        failures++; $display("FAIL rnd_esc w=%h a=%h b=%h: got %b want %b", w, a, b, obs_esc, want_esc); end
      checks++; if (obs_pcsrc !== (c == CJalr)) begin
        failures++; $display("FAIL rnd_pcsrc w=%h: got %b want %b", w, obs_pcsrc, c == CJalr); end
      if (c != CAdd) begin
        checks++; if (obs_imm !== exp_imm(c)) begin
          failures++; $display("FAIL rnd_imm w=%h: got %0d want %0d", w, obs_imm, exp_imm(c)); end
      end
      if (c != CJal) begin
        checks++; if (obs_imed !== !(c == CAdd || c == CBr)) begin
          failures++; $display("FAIL rnd_imed w=%h: got %b", w, obs_imed); end
      end
      checks++; if (obs_sub !== ((c == CBr) || (c == CAdd && w[30]))) begin
        failures++; $display("FAIL rnd_sub w=%h: got %b", w, obs_sub); end
      checks++; if (obs_apc !== (c == CAuipc)) begin
        failures++; $display("FAIL rnd_apc w=%h: got %b", w, obs_apc); end
      checks++; if (obs_ia !== obs_ib + 32'd1) begin
        failures++; $display("FAIL rnd_instret w=%h: got %0d want %0d", w, obs_ia, obs_ib + 32'd1); end
      checks++; if (obs_ir_start !== 1'b1 || obs_ir_mid !== 0 || obs_ir_next !== 1'b1) begin
        failures++; $display("FAIL rnd_ir_we w=%h: got %b/%0d/%b want 1/0/1", w, obs_ir_start,
          obs_ir_mid, obs_ir_next); end
    end
  endtask

  task automatic test_reset_mid();
    logic wer_seen;
    @(posedge clk); #1;
    bus.instr = 32'h00802203; // lw x4,8(x0)
    repeat (3) @(negedge clk); // DECOD, EXEC, MEM
    rst_n = 1'b0; #1;
    checks++; if ({bus.WeR, bus.WeM, bus.pc_we, bus.ir_we} !== 4'b0 || bus.instret !== 32'd0) begin
      failures++; $display("FAIL midreset_outputs: got %b instret=%0d want 0000 0",
        {bus.WeR, bus.WeM, bus.pc_we, bus.ir_we}, bus.instret); end
    wer_seen = 0;
    repeat (2) begin @(posedge clk); #1; wer_seen |= bus.WeR; end
    checks++; if (wer_seen !== 1'b0) begin
      failures++; $display("FAIL midreset_no_wer: got %b want 0", wer_seen); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.ir_we !== 1'b1 || bus.instret !== 32'd0) begin
      failures++; $display("FAIL midreset_restart: got ir_we=%b instret=%0d want 1 0", bus.ir_we, bus.instret); end
    exec_instr(32'h002081B3, 32'd1, 32'd2);
    checks++; if (obs_cycles !== 4 || obs_ia !== 32'd1) begin
      failures++; $display("FAIL midreset_add: got cyc=%0d instret=%0d want 4 1", obs_cycles, obs_ia); end
  endtask

  task automatic test_halt();
    logic [31:0] words [4];
    logic        errs [4];
    int          ir_cnt, pc_cnt, w_cnt;
    words = '{32'h0000007F, 32'h00000073, 32'h02208233, 32'h0010A063};
    errs  = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      exec_instr(words[i], 32'd0, 32'd0);
      checks++; if (obs_halted !== 1'b1 || obs_cycles !== 3 || obs_erro !== errs[i]) begin
        failures++; $display("FAIL halt_entry w=%h: got h=%b cyc=%0d erro=%b want 1 3 %b", words[i],
          obs_halted, obs_cycles, obs_erro, errs[i]); end
      ir_cnt = 0; pc_cnt = 0; w_cnt = 0;
      repeat (5) begin
        @(negedge clk);
        ir_cnt += int'(bus.ir_we); pc_cnt += int'(bus.pc_we); w_cnt += int'(bus.WeR | bus.WeM);
      end
      checks++; if (ir_cnt != 0 || pc_cnt != 0 || w_cnt != 0 || bus.halted !== 1'b1
                    || bus.instret !== 32'd0 || bus.erro !== errs[i]) begin
        failures++; $display("FAIL halt_stays w=%h: got ir=%0d pc=%0d w=%0d h=%b n=%0d e=%b", words[i],
          ir_cnt, pc_cnt, w_cnt, bus.halted, bus.instret, bus.erro); end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_lw();
    test_branch();
    test_jump();
    test_random();
    test_reset_mid();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
